// File: rtl/surf_wdog_pkg.sv
// Shared types and register map for the SURF housekeeping watchdog.
package surf_wdog_pkg;

  typedef enum logic [1:0] {
    ARMED     = 2'd0,
    NULLING   = 2'd1,
    TRIGGERED = 2'd2,
    HOLDOFF   = 2'd3
  } wdog_state_e;

  // Register index, taken from byte address bits [3:2]
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_STAT    = 2'd1;
  localparam logic [1:0] REG_RXIDLE  = 2'd2;
  localparam logic [1:0] REG_HOLDOFF = 2'd3;

  // CTRL bit positions
  localparam int CTRL_AUTO_BIT  = 8;
  localparam int CTRL_NCNT_LSB  = 12;
  localparam int CTRL_FORCE_BIT = 31;

  // STAT bit positions
  localparam int STAT_LIVE_LSB = 8;
  localparam int STAT_TRIG_BIT = 16;
  localparam int STAT_NULL_BIT = 17;
  localparam int STAT_CNT_LSB  = 24;

  // Null run length in bit times; a byte count of 0 behaves as 1
  function automatic logic [15:0] null_len(input logic [3:0]  n,
                                           input int unsigned bits_per_byte);
    logic [3:0] n_eff;
    n_eff = (n == 4'd0) ? 4'd1 : n;
    return 16'(32'(n_eff) * bits_per_byte);
  endfunction

endpackage

// File: rtl/hsk_bit_timer.sv
// Bit-time timer: a CLKS_PER_BIT prescaler driving a loadable down-counter
// of bit times. o_done is high in the last cycle of the loaded interval
// (or immediately when the counter holds zero).
module hsk_bit_timer #(
  parameter int CLKS_PER_BIT = 400
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [15:0] i_bits,
  output logic        o_done
);

  localparam int            PW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_BIT - 1);

  logic [PW-1:0] r_pre;
  logic [15:0]   r_bits;

  // Prescaler wraps once per bit time and decrements the remaining bit count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (!i_rst_n) begin
      r_pre  <= '0;
      r_bits <= '0;
    end else if (i_load) begin
      r_pre  <= '0;
      r_bits <= i_bits;
    end else if (r_bits != 16'd0) begin
      if (r_pre == PRE_LAST) begin
        r_pre  <= '0;
        r_bits <= r_bits - 16'd1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  assign o_done = (r_bits == 16'd0) || ((r_bits == 16'd1) && (r_pre == PRE_LAST));

endmodule

// File: rtl/surf_watchdog_ctrl.sv
// SURF housekeeping watchdog: clock-loss trigger, null-byte run toward the
// TURFIO, optional auto re-arm, RX idle-interval counter, Wishbone target.
module surf_watchdog_ctrl
  import surf_wdog_pkg::*;
#(
  parameter int NUM_SRC      = 6,
  parameter int CLKS_PER_BIT = 400,
  parameter int NULL_BITS    = 9,
  parameter int RX_IDLE_CLKS = 3400,
  parameter int WB_ADR_BITS  = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_we_i,
  input  logic [WB_ADR_BITS-1:0] wb_adr_i,
  input  logic [3:0]             wb_sel_i,
  input  logic [31:0]            wb_dat_i,
  output logic [31:0]            wb_dat_o,
  output logic                   wb_ack_o,
  output logic                   wb_err_o,
  output logic                   wb_rty_o,
  input  logic [NUM_SRC-1:0]     clk_ok_i,
  input  logic                   hsk_rx_i,
  output logic                   watchdog_trigger_o,
  output logic                   watchdog_null_o
);

  localparam int            RW       = $clog2(RX_IDLE_CLKS + 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(RX_IDLE_CLKS - 1);

  wdog_state_e        r_state, w_next;
  logic               r_ack;
  logic [NUM_SRC-1:0] r_mask, r_sticky, r_prev;
  logic               r_auto;
  logic [3:0]         r_ncnt;
  logic [15:0]        r_holdoff, r_rxidle;
  logic [7:0]         r_trig_cnt;
  logic [RW-1:0]      r_run;

  logic               w_wr, w_wr_ctrl, w_wr_stat, w_wr_hold;
  logic [1:0]         w_reg;
  logic [NUM_SRC-1:0] w_fall, w_w1c;
  logic               w_force, w_rearm, w_trig_evt;
  logic               w_tmr_load, w_tmr_done;
  logic [15:0]        w_tmr_bits;
  logic [31:0]        w_rdata;
  logic               w_unused;

  assign w_reg     = wb_adr_i[3:2];
  assign w_wr      = wb_cyc_i & wb_stb_i & wb_we_i & r_ack;
  assign w_wr_ctrl = w_wr && (w_reg == REG_CTRL);
  assign w_wr_stat = w_wr && (w_reg == REG_STAT);
  assign w_wr_hold = w_wr && (w_reg == REG_HOLDOFF);

  assign w_fall     = r_prev & ~clk_ok_i;
  assign w_w1c      = (w_wr_stat && wb_sel_i[0]) ? wb_dat_i[NUM_SRC-1:0] : '0;
  assign w_force    = w_wr_ctrl & wb_sel_i[3] & wb_dat_i[CTRL_FORCE_BIT];
  assign w_rearm    = w_wr_stat & wb_sel_i[2] & wb_dat_i[STAT_TRIG_BIT];
  assign w_trig_evt = (r_state == ARMED) && ((|(w_fall & r_mask)) || w_force);

  assign watchdog_trigger_o = (r_state != ARMED);
  assign watchdog_null_o    = (r_state == NULLING);
  assign wb_ack_o = r_ack;
  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = w_rdata;
  assign w_unused = ^{wb_adr_i, wb_dat_i, wb_sel_i};

  hsk_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_ni),
    .i_load  (w_tmr_load),
    .i_bits  (w_tmr_bits),
    .o_done  (w_tmr_done)
  );

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_state <= ARMED;
    else            r_state <= w_next;
  end

  // Next state and timer load; falls outside ARMED are ignored here
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    w_next     = r_state;
    w_tmr_load = 1'b0;
    w_tmr_bits = '0;
    case (r_state)
      ARMED: if (w_trig_evt) begin
        w_next     = NULLING;
        w_tmr_load = 1'b1;
        w_tmr_bits = null_len(r_ncnt, NULL_BITS);
      end
      NULLING: if (w_tmr_done) begin
        if (r_auto) begin
          w_next     = HOLDOFF;
          w_tmr_load = 1'b1;
          w_tmr_bits = r_holdoff;
        end else begin
          w_next = TRIGGERED;
        end
      end
      TRIGGERED: if (w_rearm)    w_next = ARMED;
      HOLDOFF:   if (w_tmr_done) w_next = ARMED;
      default:                   w_next = ARMED;
    endcase
  end

  // Wishbone ack, control registers, loss history and trigger count
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack      <= 1'b0;
      r_mask     <= '0;
      r_auto     <= 1'b0;
      r_ncnt     <= 4'd1;
      r_holdoff  <= 16'hFFFF;
      r_prev     <= '0;
      r_sticky   <= '0;
      r_trig_cnt <= '0;
    end else begin
      r_ack    <= wb_cyc_i & wb_stb_i & ~r_ack;
      r_prev   <= clk_ok_i;
      // A new fall outranks a simultaneous clear of the same bit
      r_sticky <= (r_sticky & ~w_w1c) | w_fall;
      if (w_trig_evt && (r_trig_cnt != 8'hFF)) r_trig_cnt <= r_trig_cnt + 8'd1;
      if (w_wr_ctrl && wb_sel_i[0]) r_mask <= wb_dat_i[NUM_SRC-1:0];
      if (w_wr_ctrl && wb_sel_i[1]) begin
        r_auto <= wb_dat_i[CTRL_AUTO_BIT];
        r_ncnt <= wb_dat_i[CTRL_NCNT_LSB +: 4];
      end
      if (w_wr_hold && wb_sel_i[0]) r_holdoff[7:0]  <= wb_dat_i[7:0];
      if (w_wr_hold && wb_sel_i[1]) r_holdoff[15:8] <= wb_dat_i[15:8];
    end
  end

  // RX idle: count runs of high cycles, any low cycle clears everything
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_run    <= '0;
      r_rxidle <= '0;
    end else if (!hsk_rx_i) begin
      r_run    <= '0;
      r_rxidle <= '0;
    end else if (r_run == RUN_LAST) begin
      r_run <= '0;
      if (r_rxidle != 16'hFFFF) r_rxidle <= r_rxidle + 16'd1;
    end else begin
      r_run <= r_run + 1'b1;
    end
  end

  // Read data mux
  always_comb begin
    w_rdata = '0;
    case (w_reg)
      REG_CTRL: begin
        w_rdata[NUM_SRC-1:0]          = r_mask;
        w_rdata[CTRL_AUTO_BIT]        = r_auto;
        w_rdata[CTRL_NCNT_LSB +: 4]   = r_ncnt;
      end
      REG_STAT: begin
        w_rdata[NUM_SRC-1:0]             = r_sticky;
        w_rdata[STAT_LIVE_LSB +: NUM_SRC] = clk_ok_i;
        w_rdata[STAT_TRIG_BIT]           = watchdog_trigger_o;
        w_rdata[STAT_NULL_BIT]           = watchdog_null_o;
        w_rdata[STAT_CNT_LSB +: 8]       = r_trig_cnt;
      end
      REG_RXIDLE:  w_rdata[15:0] = r_rxidle;
      REG_HOLDOFF: w_rdata[15:0] = r_holdoff;
      default:     w_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_surf_watchdog_ctrl.sv
// Scoreboard bench for surf_watchdog_ctrl: stimulus pushes expected read
// data and null-run lengths; monitors pop and compare as the DUT responds.
module tb_surf_watchdog_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  adr, sel;
  logic [31:0] dat_i, dat_o;
  logic        ack, err, rty;
  logic [5:0]  clk_ok;
  logic        hsk_rx;
  logic        w_trig, w_null;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } rd_exp_t;

  rd_exp_t     q_rd[$];
  int unsigned q_null[$];
  int unsigned null_run = 0;

  always #5 clk = ~clk;

  surf_watchdog_ctrl dut (
    .wb_clk_i           (clk),
    .wb_rst_ni          (rst_n),
    .wb_cyc_i           (cyc),
    .wb_stb_i           (stb),
    .wb_we_i            (we),
    .wb_adr_i           (adr),
    .wb_sel_i           (sel),
    .wb_dat_i           (dat_i),
    .wb_dat_o           (dat_o),
    .wb_ack_o           (ack),
    .wb_err_o           (err),
    .wb_rty_o           (rty),
    .clk_ok_i           (clk_ok),
    .hsk_rx_i           (hsk_rx),
    .watchdog_trigger_o (w_trig),
    .watchdog_null_o    (w_null)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Read monitor: compare each read ack against the oldest expectation
  always @(negedge clk) begin
    rd_exp_t e;
    if (rst_n && ack && !we) begin
      if (q_rd.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL rd_unexpected: got 0x%08h expected no read", dat_o);
      end else begin
        e = q_rd.pop_front();
        check(e.name, dat_o, e.exp);
      end
    end
  end

  // Null monitor: measure every completed null run in cycles
  always @(negedge clk) begin
    if (!rst_n) begin
      null_run = 0;
    end else if (w_null) begin
      null_run++;
    end else if (null_run != 0) begin
      if (q_null.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL null_unexpected: got %0d cycles expected no run", null_run);
      end else begin
        check("null_len", null_run, q_null.pop_front());
      end
      null_run = 0;
    end
  end

  task automatic wb_cycle(input logic w, input logic [3:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    int n;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    n = 0;
    @(posedge clk); #1;
    while (!ack && n < 8) begin
      n++;
      @(posedge clk); #1;
    end
    check("wb_ack", ack, 1);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    wb_cycle(1'b1, a, d, s);
  endtask

  task automatic wb_read(input logic [3:0] a, input logic [31:0] exp, input string nm);
    q_rd.push_back('{name: nm, exp: exp});
    wb_cycle(1'b0, a, 32'h0, 4'hF);
  endtask

  task automatic wait_null_low(input int max_cycles);
    int n;
    n = 0;
    @(negedge clk);
    while (w_null && n < max_cycles) begin
      n++;
      @(negedge clk);
    end
    check("null_fall", w_null, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cnt;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; sel = '0; dat_i = '0; clk_ok = 6'h3F; hsk_rx = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // Reset state
    check("rst_trig", w_trig, 0);
    check("rst_null", w_null, 0);
    check("rst_err_rty", {err, rty}, 0);
    wb_read(4'h0, 32'h0000_1000, "rst_ctrl");
    wb_read(4'h4, 32'h0000_3F00, "rst_stat");
    wb_read(4'h8, 32'h0000_0000, "rst_rxidle");
    wb_read(4'hC, 32'h0000_FFFF, "rst_holdoff");

    // One-shot trigger from an enabled clock loss
    wb_write(4'h0, 32'h0000_1020, 4'hF);
    q_null.push_back(3600);
    @(posedge clk); #1; clk_ok = 6'h1F;
    check("os_trig_pre", w_trig, 0);
    @(posedge clk); #1;
    check("os_trig_rise", w_trig, 1);
    check("os_null_rise", w_null, 1);
    wait_null_low(20000);
    check("os_trig_held", w_trig, 1);
    wb_read(4'h4, 32'h0101_1F20, "os_stat");
    wb_write(4'h4, 32'h0001_0000, 4'h4);
    check("os_rearm", w_trig, 0);
    clk_ok = 6'h3F;
    wb_write(4'h4, 32'h0000_0020, 4'h1);
    wb_read(4'h4, 32'h0100_3F00, "os_stat_clr");

    // Auto re-arm, forced trigger, N=3, holdoff of 2 bit times
    wb_write(4'hC, 32'h0000_0002, 4'h3);
    wb_write(4'h0, 32'h0000_3120, 4'hF);
    q_null.push_back(10800);
    wb_write(4'h0, 32'h8000_3120, 4'hF);
    check("ar_trig_rise", w_trig, 1);
    check("ar_null_rise", w_null, 1);
    wait_null_low(20000);
    cnt = 0;
    while (w_trig && cnt < 5000) begin
      if (cnt == 100) clk_ok = 6'h1F;
      cnt++;
      @(negedge clk);
    end
    check("ar_holdoff_len", cnt, 800);
    wb_read(4'h4, 32'h0200_1F20, "ar_stat");
    wb_read(4'h0, 32'h0000_3120, "ar_ctrl_force_rd0");
    clk_ok = 6'h3F;
    wb_write(4'h4, 32'h0000_0020, 4'h1);

    // Disabled source: sticky only; set wins over a coincident clear
    wb_write(4'h0, 32'h0000_0000, 4'hF);
    @(negedge clk); clk_ok = 6'h3E;
    repeat (3) @(posedge clk); #1;
    check("dis_no_trig", w_trig, 0);
    wb_read(4'h4, 32'h0200_3E01, "dis_stat");
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'h4; dat_i = 32'h0000_0002; sel = 4'h1;
    @(posedge clk); #1;
    check("w1c_ack", ack, 1);
    clk_ok = 6'h3C;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    wb_read(4'h4, 32'h0200_3C03, "set_wins");
    wb_write(4'h4, 32'h0000_0001, 4'h1);
    wb_read(4'h4, 32'h0200_3C02, "w1c_bit0");
    clk_ok = 6'h3F;
    wb_write(4'h4, 32'h0000_0002, 4'h1);

    // RX idle intervals
    @(posedge clk); #1; hsk_rx = 1'b1;
    repeat (10200) @(posedge clk);
    wb_read(4'h8, 32'h0000_0003, "rxidle_3");
    hsk_rx = 1'b0;
    @(posedge clk); #1; hsk_rx = 1'b1;
    wb_read(4'h8, 32'h0000_0000, "rxidle_clr");

    // Reset in the middle of a null run
    wb_write(4'h0, 32'h0000_1020, 4'hF);
    wb_write(4'h0, 32'h8000_1020, 4'hF);
    check("mr_null_before", w_null, 1);
    repeat (100) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    check("mr_trig_async", w_trig, 0);
    check("mr_null_async", w_null, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    wb_read(4'h0, 32'h0000_1000, "mr_ctrl");
    wb_read(4'hC, 32'h0000_FFFF, "mr_holdoff");
    wb_read(4'h4, 32'h0000_3F00, "mr_stat");
    wb_write(4'h0, 32'h0000_1020, 4'hF);
    q_null.push_back(3600);
    @(posedge clk); #1; clk_ok = 6'h1F;
    @(posedge clk); #1;
    check("mr_trig_rise", w_trig, 1);
    check("mr_null_rise", w_null, 1);
    wait_null_low(20000);
    wb_read(4'h4, 32'h0101_1F20, "mr_stat_after");

    repeat (5) @(posedge clk);
    check("rd_queue_drained", q_rd.size(), 0);
    check("null_queue_drained", q_null.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
